// File: rtl/repadd_arbiter_if.sv
// Bundle of requester-side and datapath-side signals for the round-robin
// repeated-addition multiplier scheduler.

interface repadd_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_product;
    logic              ldA;
    logic              ldB;
    logic              clrP;
    logic              ldP;
    logic              decB;
    logic [W-1:0]      din;
    logic              eqz;
    logic [W-1:0]      dp_prod;

    // master is the scheduler itself; slave is everything around it
    modport master (
        input  req, a_in, b_in, eqz, dp_prod,
        output gnt, busy, rsp_valid, rsp_id, rsp_product,
        output ldA, ldB, clrP, ldP, decB, din
    );

    modport slave (
        output req, a_in, b_in, eqz, dp_prod,
        input  gnt, busy, rsp_valid, rsp_id, rsp_product,
        input  ldA, ldB, clrP, ldP, decB, din
    );
endinterface

// File: rtl/repadd_arbiter.sv
// Round-robin scheduler sharing one repeated-addition multiplier datapath
// between NREQ requesters; returns each product tagged with its requester ID.

module repadd_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    repadd_arbiter_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LDA  = 3'd1,
        LDB  = 3'd2,
        ACC  = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_cap_q, a_cap_d;
    logic [W-1:0]   b_cap_q, b_cap_d;
    logic [W-1:0]   prod_q, prod_d;
    int             win_idx;

    // Scan offsets last+1 .. last+NREQ; iterating downward lets the nearest set bit win.
    function automatic int rr_pick(input logic [NREQ-1:0] r, input logic [IDW-1:0] last);
        int pick;
        int idx;
        pick = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NREQ;
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        win_idx = rr_pick(bus.req, last_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_cap_q <= '0;
            b_cap_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_cap_q <= a_cap_d;
            b_cap_q <= b_cap_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_cap_d = a_cap_q;
        b_cap_d = b_cap_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    id_d    = IDW'(win_idx);
                    a_cap_d = bus.a_in[win_idx*W +: W];
                    b_cap_d = bus.b_in[win_idx*W +: W];
                    state_d = LDA;
                end
            end
            LDA: state_d = LDB;
            LDB: state_d = ACC;
            ACC: begin
                if (bus.eqz) begin
                    prod_d  = bus.dp_prod;
                    state_d = RSP;
                end
            end
            RSP: begin
                last_d  = id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from state only, except ldP/decB which also follow eqz in ACC.
    always_comb begin
        bus.gnt         = '0;
        bus.busy        = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_id      = '0;
        bus.rsp_product = '0;
        bus.ldA         = 1'b0;
        bus.ldB         = 1'b0;
        bus.clrP        = 1'b0;
        bus.ldP         = 1'b0;
        bus.decB        = 1'b0;
        bus.din         = '0;
        case (state_q)
            LDA: begin
                bus.gnt  = NREQ'(1) << id_q;
                bus.busy = 1'b1;
                bus.din  = a_cap_q;
                bus.ldA  = 1'b1;
            end
            LDB: begin
                bus.busy = 1'b1;
                bus.din  = b_cap_q;
                bus.ldB  = 1'b1;
                bus.clrP = 1'b1;
            end
            ACC: begin
                bus.busy = 1'b1;
                bus.ldP  = ~bus.eqz;
                bus.decB = ~bus.eqz;
            end
            RSP: begin
                bus.busy        = 1'b1;
                bus.rsp_valid   = 1'b1;
                bus.rsp_id      = id_q;
                bus.rsp_product = prod_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_repadd_arbiter.sv
// Scoreboard bench for repadd_arbiter with a behavioural A/B/P datapath
// attached to the strobes.

module tb_repadd_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int W    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    repadd_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .W(W)) bus ();

    repadd_arbiter #(.NREQ(NREQ), .IDW(IDW), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [W-1:0] regA = '0;
    logic [W-1:0] regB = '0;
    logic [W-1:0] regP = '0;

    always @(posedge clk) begin
        if (bus.ldA) regA <= bus.din;
        if (bus.ldB) regB <= bus.din;
        else if (bus.decB) regB <= regB - 1'b1;
        if (bus.clrP) regP <= '0;
        else if (bus.ldP) regP <= regP + regA;
    end

    assign bus.eqz     = (regB == '0);
    assign bus.dp_prod = regP;

    typedef struct {
        int           id;
        logic [W-1:0] prod;
        int           lat;
        int           ldp;
    } exp_t;

    exp_t rspQ[$];
    int   gntQ[$];
    int   jobsLeft[NREQ];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;
    int   grantCycle = 0;
    int   ldpCount   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit expectRsp);
        exp_t e;
        bus.a_in[id*W +: W] = a;
        bus.b_in[id*W +: W] = b;
        bus.req[id]         = 1'b1;
        jobsLeft[id]++;
        gntQ.push_back(id);
        if (expectRsp) begin
            e.id   = id;
            e.prod = W'(32'(a) * 32'(b));
            e.lat  = int'(b) + 3;
            e.ldp  = int'(b);
            rspQ.push_back(e);
        end
    endtask

    // Requesters hold req until their last queued job is granted.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                jobsLeft[i]--;
                if (jobsLeft[i] <= 0) begin
                    jobsLeft[i] = 0;
                    bus.req[i]  = 1'b0;
                end
            end
        end
    endtask

    task automatic waitIdle(input string tag, input int maxCycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxCycles && !done; i++) begin
            tick();
            if (gntQ.size() == 0 && rspQ.size() == 0 && bus.req == '0 && !bus.busy) done = 1'b1;
        end
        checkOutput({tag, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic waitGnt(input int id, input int maxCycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCycles && !seen; i++) begin
            tick();
            if (bus.gnt[id]) seen = 1'b1;
        end
        checkOutput("gnt_wait", 32'(seen), 32'd1);
    endtask

    task automatic resetChecks(input string tag);
        checkOutput({tag, "_ctrl"},
                    32'({bus.gnt, bus.busy, bus.rsp_valid, bus.rsp_id,
                         bus.ldA, bus.ldB, bus.clrP, bus.ldP, bus.decB}), 32'd0);
        checkOutput({tag, "_prod"}, 32'(bus.rsp_product), 32'd0);
        checkOutput({tag, "_din"},  32'(bus.din), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   g;
        cycle++;
        if (!rst_n) begin
            ldpCount = 0;
        end else begin
            if (bus.ldP) ldpCount++;
            if (bus.ldP || bus.decB) checkOutput("ldp_decb", 32'(bus.decB), 32'(bus.ldP));
            if (bus.gnt != '0) begin
                if (gntQ.size() == 0) begin
                    checkOutput("unexp_gnt", 32'(bus.gnt), 32'd0);
                end else begin
                    g = gntQ.pop_front();
                    checkOutput("gnt", 32'(bus.gnt), 32'd1 << g);
                end
                checkOutput("gnt_busy", 32'(bus.busy), 32'd1);
                checkOutput("gnt_rsp_excl", 32'(bus.rsp_valid), 32'd0);
                grantCycle = cycle;
                ldpCount   = 0;
            end
            if (bus.rsp_valid) begin
                if (rspQ.size() == 0) begin
                    checkOutput("unexp_rsp", 32'(bus.rsp_valid), 32'd0);
                end else begin
                    e = rspQ.pop_front();
                    checkOutput("rsp_id", 32'(bus.rsp_id), 32'(e.id));
                    checkOutput("rsp_product", 32'(bus.rsp_product), 32'(e.prod));
                    checkOutput("rsp_latency", 32'(cycle - grantCycle), 32'(e.lat));
                    checkOutput("ldp_cycles", 32'(ldpCount), 32'(e.ldp));
                end
            end
        end
    end

    initial begin
        bus.req  = '0;
        bus.a_in = '0;
        bus.b_in = '0;
        for (int i = 0; i < NREQ; i++) jobsLeft[i] = 0;

        #2 rst_n = 1'b0;
        #1 resetChecks("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single job: 7*3 on requester 2
        applyStimulus(2, 16'd7, 16'd3, 1'b1);
        waitIdle("single", 60);

        // overflow wraps modulo 2^16; leaves requester 3 as last granted
        applyStimulus(3, 16'hFFFF, 16'd2, 1'b1);
        waitIdle("overflow", 60);

        // all four contend; requester 0 asks twice, wrap brings it back after 3
        applyStimulus(0, 16'd3,  16'd1, 1'b1);
        applyStimulus(1, 16'd5,  16'd1, 1'b1);
        applyStimulus(2, 16'd11, 16'd1, 1'b1);
        applyStimulus(3, 16'd13, 16'd1, 1'b1);
        applyStimulus(0, 16'd3,  16'd1, 1'b1);
        waitIdle("rr", 120);

        // B=0 gives an immediate product of 0
        applyStimulus(0, 16'd9, 16'd0, 1'b1);
        waitIdle("bzero", 60);

        // operands changed mid-job must not affect the result
        applyStimulus(1, 16'd6, 16'd4, 1'b1);
        waitGnt(1, 20);
        repeat (3) tick();
        bus.a_in[1*W +: W] = 16'd100;
        bus.b_in[1*W +: W] = 16'd1;
        waitIdle("stable", 60);

        // reset during ACC abandons the job; priority restarts at requester 0
        applyStimulus(1, 16'd5, 16'd10, 1'b0);
        waitGnt(1, 20);
        repeat (5) tick();
        checkOutput("pre_rst_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1 resetChecks("midjob_rst");
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(3, 16'd2, 16'd3, 1'b1);
        waitIdle("post_rst", 60);

        checkOutput("sb_rsp_empty", 32'(rspQ.size()), 32'd0);
        checkOutput("sb_gnt_empty", 32'(gntQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
